pipe_stage_reg: RTL

Parametrised pipeline boundary register that generalises the fixed fetch/decode latch to any stage of the CPU pipeline. The stage index, payload width, stall-vector width and bubble value are configurable. It adds an explicit valid bit, a saturating stall-cycle counter, and an optional one-entry capture buffer that holds data returned by synchronous memories during a stall. One instance sits between each pair of adjacent stages, driven by the common stall controller and the exception flush line.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_capture_buf.sv | 50 +++++
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the stage-boundary bundle type.
// Consumed by pipe_stage_reg and pipe_capture_buf.
package pipe_pkg;

    localparam int DEF_STALL_W = 6;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_PC_W    = 32;
    localparam int DEF_EXC_W   = 32;
    localparam int EXC_TYPE_W  = DEF_EXC_W;

    localparam logic [DEF_DATA_W-1:0] NOP_INSN = '0;

    typedef struct packed {
        logic                  valid;
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] data;
        logic [EXC_TYPE_W-1:0] exc;
    } pipe_bundle_t;

endpackage

// File: rtl/pipe_capture_buf.sv
// One-entry holding buffer for data returned by a synchronous memory
// while the consuming stage is stalled.
module pipe_capture_buf
    import pipe_pkg::*;
#(
    parameter int W = $bits(pipe_bundle_t)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic         drain_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (drain_i && full_q) begin
            full_d = 1'b0;
        end else if (load_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload needs no reset: it is only observed while full_q is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid, bubble, flush and stall counter.
// Define PIPE_CAPTURE_EN to add the one-entry stall capture buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                STALL_W = DEF_STALL_W,
    parameter int                STAGE   = 1,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                PC_W    = DEF_PC_W,
    parameter int                EXC_W   = DEF_EXC_W,
    parameter logic [DATA_W-1:0] NOP     = {DATA_W{1'b0}},
    parameter int                CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               valid_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [EXC_W-1:0]   exc_i,
    output logic               valid_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [EXC_W-1:0]   exc_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam int BW = 1 + PC_W + DATA_W + EXC_W;

    logic up, dn;
    logic stall_unused;

    assign up = stall[STAGE];
    assign dn = stall[STAGE+1];
    assign stall_unused = ^stall;

    logic [BW-1:0] live, src;

    assign live = {valid_i, pc_i, data_i, exc_i};

`ifdef PIPE_CAPTURE_EN
    logic          buf_full;
    logic [BW-1:0] buf_data;

    pipe_capture_buf #(.W(BW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (up && valid_i),
        .drain_i (!up),
        .data_i  (live),
        .full_o  (buf_full),
        .data_o  (buf_data)
    );

    assign src = buf_full ? buf_data : live;
`else
    assign src = live;
`endif

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        exc_d   = exc_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            data_d  = NOP;
            exc_d   = '0;
        end else if (up && !dn) begin
            // PC still tracks so EPC stays meaningful across a bubble.
            valid_d = 1'b0;
            pc_d    = pc_i;
            data_d  = NOP;
            exc_d   = '0;
        end else if (!up) begin
            {valid_d, pc_d, data_d, exc_d} = src;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (up && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= NOP;
            exc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign pc_o        = pc_q;
    assign data_o      = data_q;
    assign exc_o       = exc_q;
    assign stall_cnt_o = cnt_q;

endmodule
